pc_fetch_ctrl: RTL and testbench

//  Program-counter stage directly upstream of the instruction-fetch memory interface.

---
 rtl/pc_fetch_ctrl_if.sv | 33 +++
 rtl/pc_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side handshake bundle between the PC stage, the instruction memory port and decode.
// The PC stage drives through the slave modport; the environment (memory/exec/decode) uses master.
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

interface pc_fetch_ctrl_if;
    logic                   stall_IF_i;
    logic                   stall_EXEC_i;
    logic                   branch_taken_i;
    logic [`size_X_LEN-1:0] branch_target_i;
    logic                   halt_i;
    logic                   fetch_retire_i;
    logic [`size_X_LEN-1:0] pc_o;
    logic                   pc_valid_o;
    logic                   abort_rvalid_o;
    logic                   stop_request_overide_o;
    logic [`size_X_LEN-1:0] pc_decode_o;
    logic                   pc_decode_valid_o;
    logic                   misalign_o;

    modport master (
        output stall_IF_i, stall_EXEC_i, branch_taken_i, branch_target_i, halt_i, fetch_retire_i,
        input  pc_o, pc_valid_o, abort_rvalid_o, stop_request_overide_o,
               pc_decode_o, pc_decode_valid_o, misalign_o
    );

    modport slave (
        input  stall_IF_i, stall_EXEC_i, branch_taken_i, branch_target_i, halt_i, fetch_retire_i,
        output pc_o, pc_valid_o, abort_rvalid_o, stop_request_overide_o,
               pc_decode_o, pc_decode_valid_o, misalign_o
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC generator for instruction fetch with in-flight PC tracking for decode.
// Latency: pc_o advances one cycle after accept; pc_decode_o lags the FIFO head by one cycle.
// Backpressure: stall_IF_i/stall_EXEC_i or a full tracking FIFO hold pc_o; BRANCH_MISALIGN_CHECK_EN enables misaligned-target halt.
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

module pc_fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    input  logic                   rd_rdy,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pop on empty is dropped; push into a full FIFO only proceeds alongside a pop.
    assign do_pop  = rd_rdy && (count != '0);
    assign do_push = wr_vld && ((count != FULL_CNT) || do_pop);
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_dat;
    end
endmodule

module pc_fetch_ctrl #(
    parameter logic [`size_X_LEN-1:0] RESET_PC    = '0,
    parameter int                     TRACK_DEPTH = 2
) (
    input logic          clk,
    input logic          reset,
    pc_fetch_ctrl_if.slave fif
);
    localparam int XLEN = `size_X_LEN;
    localparam int CW   = $clog2(TRACK_DEPTH) + 1;
    localparam logic [CW-1:0]   FULL_CNT   = CW'(TRACK_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_decode_q;
    logic            pc_decode_valid_q;
    logic            pc_valid;
    logic            stop_req;
    logic            accept;
    logic            fifo_full_no_pop;
    logic            misalign_hit;
    logic [XLEN-1:0] fifo_head;
    logic [CW-1:0]   fifo_count;

`ifdef BRANCH_MISALIGN_CHECK_EN
    logic misalign_q;
    assign misalign_hit = fif.branch_taken_i && (fif.branch_target_i[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset)             misalign_q <= 1'b0;
        else if (misalign_hit) misalign_q <= 1'b1;
    end
    assign fif.misalign_o = misalign_q;
`else
    assign misalign_hit   = 1'b0;
    assign fif.misalign_o = 1'b0;
`endif

    assign fifo_full_no_pop = (fifo_count == FULL_CNT) && !fif.fetch_retire_i;
    assign accept           = pc_valid && !fif.stall_IF_i && !fif.stall_EXEC_i;

    always_ff @(posedge clk) begin
        if (reset) state <= S_BOOT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pc_valid  = 1'b0;
        stop_req  = fif.branch_taken_i;
        case (state)
            S_BOOT: begin
                stop_req  = 1'b1;
                state_nxt = fif.halt_i ? S_HALT : S_RUN;
            end
            S_RUN: begin
                pc_valid = !fifo_full_no_pop && !fif.branch_taken_i;
                if (fif.halt_i) state_nxt = S_HALT;
            end
            S_HALT: begin
                stop_req = 1'b1;
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
        if (misalign_hit) state_nxt = S_HALT;
    end

    // Redirect has priority; the low target bits are always dropped so fetches stay word aligned.
    always_ff @(posedge clk) begin
        if (reset)                   pc_q <= RESET_PC;
        else if (fif.branch_taken_i) pc_q <= fif.branch_target_i & ALIGN_MASK;
        else if (accept)             pc_q <= pc_q + PC_STEP;
    end

    pc_fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (TRACK_DEPTH)
    ) u_track_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (fif.branch_taken_i),
        .wr_vld (accept),
        .wr_dat (pc_q),
        .rd_rdy (fif.fetch_retire_i),
        .rd_dat (fifo_head),
        .count  (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_decode_q       <= '0;
            pc_decode_valid_q <= 1'b0;
        end else begin
            pc_decode_q       <= fifo_head;
            pc_decode_valid_q <= (fifo_count != '0);
        end
    end

    assign fif.pc_o                   = pc_q;
    assign fif.pc_valid_o             = pc_valid;
    assign fif.abort_rvalid_o         = fif.branch_taken_i;
    assign fif.stop_request_overide_o = stop_req;
    assign fif.pc_decode_o            = pc_decode_q;
    assign fif.pc_decode_valid_o      = pc_decode_valid_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: sequencing, stalls, FIFO full, branch flush, wrap, halt.
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

module tb_pc_fetch_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    pc_fetch_ctrl_if fif();

    pc_fetch_ctrl #(
        .RESET_PC    (32'h0000_0000),
        .TRACK_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    always #5 clk = ~clk;

`ifdef BRANCH_MISALIGN_CHECK_EN
    localparam logic EXP_MISALIGN = 1'b1;
`else
    localparam logic EXP_MISALIGN = 1'b0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fif.stall_IF_i      = 1'b0;
        fif.stall_EXEC_i    = 1'b0;
        fif.branch_taken_i  = 1'b0;
        fif.branch_target_i = '0;
        fif.halt_i          = 1'b0;
        fif.fetch_retire_i  = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        checks++; if (fif.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", fif.pc_o, 32'h0); end
        checks++; if (fif.pc_valid_o !== 1'b0) begin errors++; $display("FAIL reset_pc_valid got=%b exp=0", fif.pc_valid_o); end
        checks++; if (fif.abort_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_abort got=%b exp=0", fif.abort_rvalid_o); end
        checks++; if (fif.pc_decode_valid_o !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got=%b exp=0", fif.pc_decode_valid_o); end
        checks++; if (fif.pc_decode_o !== 32'h0) begin errors++; $display("FAIL reset_dec_pc got=%h exp=0", fif.pc_decode_o); end
        checks++; if (fif.misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", fif.misalign_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
        do_reset();
        fif.fetch_retire_i = 1'b1;
        #1;
        checks++; if (fif.pc_valid_o !== 1'b0) begin errors++; $display("FAIL seq_boot_valid got=%b exp=0", fif.pc_valid_o); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (fif.pc_o !== exp_pc[i]) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, fif.pc_o, exp_pc[i]); end
            checks++; if (fif.pc_valid_o !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, fif.pc_valid_o); end
        end
        checks++; if (fif.pc_decode_valid_o !== 1'b1) begin errors++; $display("FAIL seq_dec_valid got=%b exp=1", fif.pc_decode_valid_o); end
        checks++; if (fif.pc_decode_o !== 32'h4) begin errors++; $display("FAIL seq_dec_pc got=%h exp=%h", fif.pc_decode_o, 32'h4); end
    endtask

    task automatic test_stall();
        do_reset();
        fif.fetch_retire_i = 1'b1;
        step(); step(); step();
        checks++; if (fif.pc_o !== 32'h8) begin errors++; $display("FAIL stall_pre_pc got=%h exp=%h", fif.pc_o, 32'h8); end
        fif.stall_IF_i = 1'b1;
        #1;
        checks++; if (fif.pc_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid got=%b exp=1", fif.pc_valid_o); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (fif.pc_o !== 32'h8) begin errors++; $display("FAIL stall_hold_pc[%0d] got=%h exp=%h", i, fif.pc_o, 32'h8); end
            if (i >= 1) begin
                checks++; if (fif.pc_decode_valid_o !== 1'b0) begin errors++; $display("FAIL stall_no_push[%0d] got=%b exp=0", i, fif.pc_decode_valid_o); end
            end
        end
        fif.stall_IF_i = 1'b0;
        step();
        checks++; if (fif.pc_o !== 32'hC) begin errors++; $display("FAIL stall_resume_pc got=%h exp=%h", fif.pc_o, 32'hC); end
    endtask

    task automatic test_full();
        do_reset();
        step(); step(); step();
        checks++; if (fif.pc_valid_o !== 1'b0) begin errors++; $display("FAIL full_valid got=%b exp=0", fif.pc_valid_o); end
        checks++; if (fif.pc_o !== 32'h8) begin errors++; $display("FAIL full_pc got=%h exp=%h", fif.pc_o, 32'h8); end
        step();
        checks++; if (fif.pc_o !== 32'h8) begin errors++; $display("FAIL full_hold_pc got=%h exp=%h", fif.pc_o, 32'h8); end
        checks++; if (fif.pc_decode_o !== 32'h0) begin errors++; $display("FAIL full_dec_pc got=%h exp=%h", fif.pc_decode_o, 32'h0); end
        fif.fetch_retire_i = 1'b1;
        #1;
        checks++; if (fif.pc_valid_o !== 1'b1) begin errors++; $display("FAIL full_pop_valid got=%b exp=1", fif.pc_valid_o); end
        step();
        fif.fetch_retire_i = 1'b0;
        #1;
        checks++; if (fif.pc_o !== 32'hC) begin errors++; $display("FAIL full_resume_pc got=%h exp=%h", fif.pc_o, 32'hC); end
        checks++; if (fif.pc_valid_o !== 1'b0) begin errors++; $display("FAIL full_again_valid got=%b exp=0", fif.pc_valid_o); end
        step();
        checks++; if (fif.pc_decode_o !== 32'h4) begin errors++; $display("FAIL full_dec_after_retire got=%h exp=%h", fif.pc_decode_o, 32'h4); end
    endtask

    task automatic test_branch();
        do_reset();
        step(); step(); step();
        fif.branch_taken_i  = 1'b1;
        fif.branch_target_i = 32'h100;
        #1;
        checks++; if (fif.abort_rvalid_o !== 1'b1) begin errors++; $display("FAIL br_abort got=%b exp=1", fif.abort_rvalid_o); end
        checks++; if (fif.pc_valid_o !== 1'b0) begin errors++; $display("FAIL br_valid got=%b exp=0", fif.pc_valid_o); end
        checks++; if (fif.stop_request_overide_o !== 1'b1) begin errors++; $display("FAIL br_stop got=%b exp=1", fif.stop_request_overide_o); end
        step();
        fif.branch_taken_i = 1'b0;
        #1;
        checks++; if (fif.pc_o !== 32'h100) begin errors++; $display("FAIL br_pc got=%h exp=%h", fif.pc_o, 32'h100); end
        checks++; if (fif.abort_rvalid_o !== 1'b0) begin errors++; $display("FAIL br_abort_drop got=%b exp=0", fif.abort_rvalid_o); end
        checks++; if (fif.pc_valid_o !== 1'b1) begin errors++; $display("FAIL br_new_valid got=%b exp=1", fif.pc_valid_o); end
        step();
        checks++; if (fif.pc_decode_valid_o !== 1'b0) begin errors++; $display("FAIL br_flushed got=%b exp=0", fif.pc_decode_valid_o); end
        checks++; if (fif.pc_o !== 32'h104) begin errors++; $display("FAIL br_next_pc got=%h exp=%h", fif.pc_o, 32'h104); end
    endtask

    task automatic test_wrap_misalign();
        do_reset();
        step();
        fif.branch_taken_i  = 1'b1;
        fif.branch_target_i = 32'hFFFF_FFFC;
        step();
        fif.branch_taken_i = 1'b0;
        fif.fetch_retire_i = 1'b1;
        #1;
        checks++; if (fif.pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_pc got=%h exp=%h", fif.pc_o, 32'hFFFF_FFFC); end
        step();
        checks++; if (fif.pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", fif.pc_o, 32'h0); end
        fif.branch_taken_i  = 1'b1;
        fif.branch_target_i = 32'h102;
        step();
        fif.branch_taken_i = 1'b0;
        #1;
        checks++; if (fif.pc_o !== 32'h100) begin errors++; $display("FAIL mis_pc got=%h exp=%h", fif.pc_o, 32'h100); end
        checks++; if (fif.misalign_o !== EXP_MISALIGN) begin errors++; $display("FAIL mis_flag got=%b exp=%b", fif.misalign_o, EXP_MISALIGN); end
        checks++; if (fif.pc_valid_o !== !EXP_MISALIGN) begin errors++; $display("FAIL mis_valid got=%b exp=%b", fif.pc_valid_o, !EXP_MISALIGN); end
    endtask

    task automatic test_halt();
        do_reset();
        fif.fetch_retire_i = 1'b1;
        step(); step();
        fif.halt_i = 1'b1;
        #1;
        checks++; if (fif.pc_valid_o !== 1'b1) begin errors++; $display("FAIL halt_same_cycle_valid got=%b exp=1", fif.pc_valid_o); end
        step();
        fif.halt_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (fif.pc_valid_o !== 1'b0) begin errors++; $display("FAIL halt_valid[%0d] got=%b exp=0", i, fif.pc_valid_o); end
            checks++; if (fif.stop_request_overide_o !== 1'b1) begin errors++; $display("FAIL halt_stop[%0d] got=%b exp=1", i, fif.stop_request_overide_o); end
            checks++; if (fif.pc_o !== 32'h8) begin errors++; $display("FAIL halt_pc[%0d] got=%h exp=%h", i, fif.pc_o, 32'h8); end
            step();
        end
        reset = 1'b1;
        step();
        checks++; if (fif.pc_o !== 32'h0) begin errors++; $display("FAIL halt_reset_pc got=%h exp=%h", fif.pc_o, 32'h0); end
        checks++; if (fif.pc_decode_valid_o !== 1'b0) begin errors++; $display("FAIL halt_reset_dec got=%b exp=0", fif.pc_decode_valid_o); end
        reset = 1'b0;
        step();
        checks++; if (fif.pc_valid_o !== 1'b1) begin errors++; $display("FAIL halt_restart_valid got=%b exp=1", fif.pc_valid_o); end
    endtask

    task automatic test_branch_halt();
        do_reset();
        step();
        fif.branch_taken_i  = 1'b1;
        fif.branch_target_i = 32'h200;
        fif.halt_i          = 1'b1;
        step();
        fif.branch_taken_i = 1'b0;
        fif.halt_i         = 1'b0;
        #1;
        checks++; if (fif.pc_o !== 32'h200) begin errors++; $display("FAIL brhalt_pc got=%h exp=%h", fif.pc_o, 32'h200); end
        checks++; if (fif.pc_valid_o !== 1'b0) begin errors++; $display("FAIL brhalt_valid got=%b exp=0", fif.pc_valid_o); end
        checks++; if (fif.stop_request_overide_o !== 1'b1) begin errors++; $display("FAIL brhalt_stop got=%b exp=1", fif.stop_request_overide_o); end
    endtask

    task automatic test_boot_halt();
        do_reset();
        fif.halt_i = 1'b1;
        step();
        fif.halt_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (fif.pc_valid_o !== 1'b0) begin errors++; $display("FAIL boothalt_valid[%0d] got=%b exp=0", i, fif.pc_valid_o); end
            checks++; if (fif.pc_decode_valid_o !== 1'b0) begin errors++; $display("FAIL boothalt_dec[%0d] got=%b exp=0", i, fif.pc_decode_valid_o); end
            step();
        end
        checks++; if (fif.pc_o !== 32'h0) begin errors++; $display("FAIL boothalt_pc got=%h exp=%h", fif.pc_o, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_full();
        test_branch();
        test_wrap_misalign();
        test_halt();
        test_branch_halt();
        test_boot_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
